// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, write-back source
// select encodings and load-type encodings used by the MEM/WB stage.
package mips_pkg;

  localparam int MIP_BUS = 32;

  // write-back source select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  // load types; any other code behaves as LW
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

endpackage

// File: rtl/load_align.sv
// Sub-word load extraction (combinational).
// Picks the byte/halfword addressed by off_i from a big-endian word
// (offset 0 = most significant lane) and sign- or zero-extends it.
// Ports:
//   data_i  [MIP_BUS]  raw word from data memory
//   off_i   [2]        byte offset within the word
//   ltype_i [3]        load type (LW/LB/LBU/LH/LHU, others as LW)
//   data_o  [MIP_BUS]  aligned, extended load result
module load_align
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic [1:0]   off_i,
  input  logic [2:0]   ltype_i,
  output logic [W-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = data_i[W-1 -: 8];
    case (off_i)
      2'd0:    byte_v = data_i[W-1  -: 8];
      2'd1:    byte_v = data_i[W-9  -: 8];
      2'd2:    byte_v = data_i[W-17 -: 8];
      default: byte_v = data_i[W-25 -: 8];
    endcase
  end

  // halfwords sit at offsets 0/2; off_i[0] is don't-care
  assign half_v = off_i[1] ? data_i[W-17 -: 16] : data_i[W-1 -: 16];

  always_comb begin
    data_o = data_i;
    case (ltype_i)
      LD_B:    data_o = {{(W-8){byte_v[7]}}, byte_v};
      LD_BU:   data_o = {{(W-8){1'b0}}, byte_v};
      LD_H:    data_o = {{(W-16){half_v[15]}}, half_v};
      LD_HU:   data_o = {{(W-16){1'b0}}, half_v};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux and retire counter.
// One-entry stage, 1-cycle latency from mem_* inputs to WB outputs.
// Write_data/RegWrite are decoded combinationally from registered
// fields only, so they are stable for the whole cycle (the register
// file writes level-sensitively).
// Optional feature: define WB_LOAD_EXT_EN for sub-word load extraction
// (LB/LBU/LH/LHU); otherwise load data passes through unchanged.
// Ports:
//   clk, rst            clock, async active-high reset
//   mem_*               instruction fields from the MEM stage
//   stall / flush       hold stage / squash incoming (flush wins)
//   RegWrite, Write_register, Write_data   register-file write port
//   wb_valid            stage holds a valid instruction
//   retired             wrapping count of retired instructions
module mem_wb_stage #(
  parameter int MIP_BUS = mips_pkg::MIP_BUS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  input  logic               mem_regwrite,
  input  logic [1:0]         mem_wbsel,
  input  logic [4:0]         mem_rd,
  input  logic [MIP_BUS-1:0] mem_alu_result,
  input  logic [MIP_BUS-1:0] mem_load_data,
  input  logic [MIP_BUS-1:0] mem_pc_plus8,
  input  logic [2:0]         mem_load_type,
  input  logic               stall,
  input  logic               flush,
  output logic               RegWrite,
  output logic [4:0]         Write_register,
  output logic [MIP_BUS-1:0] Write_data,
  output logic               wb_valid,
  output logic [31:0]        retired
);
  import mips_pkg::*;

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic [1:0]         wbsel;
    logic [4:0]         rd;
    logic [MIP_BUS-1:0] alu;
    logic [MIP_BUS-1:0] ld;
    logic [MIP_BUS-1:0] pc8;
  } stage_t;

  stage_t      stage_d, stage_q;
  logic [31:0] retired_d, retired_q;
  logic        retire;
  logic [MIP_BUS-1:0] load_res;

  // Outgoing instruction retires whenever the stage advances, even if
  // the incoming one is being flushed on the same edge.
  assign retire = stage_q.valid & ~stall;

  always_comb begin
    stage_d   = stage_q;
    retired_d = retired_q + {31'd0, retire};
    if (flush) begin
      stage_d.valid    = 1'b0;
      stage_d.regwrite = 1'b0;
    end else if (!stall) begin
      stage_d.valid    = mem_valid;
      stage_d.regwrite = mem_regwrite;
      stage_d.wbsel    = mem_wbsel;
      stage_d.rd       = mem_rd;
      stage_d.alu      = mem_alu_result;
      stage_d.ld       = mem_load_data;
      stage_d.pc8      = mem_pc_plus8;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] ltype_d, ltype_q;

  always_comb begin
    ltype_d = ltype_q;
    if (!flush && !stall) ltype_d = mem_load_type;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ltype_q <= '0;
    else     ltype_q <= ltype_d;
  end

  load_align #(.W(MIP_BUS)) u_load_align (
    .data_i  (stage_q.ld),
    .off_i   (stage_q.alu[1:0]),
    .ltype_i (ltype_q),
    .data_o  (load_res)
  );
`else
  logic unused_ltype;
  assign unused_ltype = ^mem_load_type;
  assign load_res     = stage_q.ld;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q   <= '0;
      retired_q <= '0;
    end else begin
      stage_q   <= stage_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    Write_data = '0;
    case (stage_q.wbsel)
      WB_ALU:  Write_data = stage_q.alu;
      WB_LOAD: Write_data = load_res;
      WB_LINK: Write_data = stage_q.pc8;
      default: Write_data = '0;
    endcase
  end

  // r0 is hard-wired zero and the reserved select never writes
  assign RegWrite       = stage_q.valid & stage_q.regwrite &
                          (stage_q.rd != 5'd0) & (stage_q.wbsel != WB_RSVD);
  assign Write_register = stage_q.rd;
  assign wb_valid       = stage_q.valid;
  assign retired        = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int W = 32;
`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_valid = 0, mem_regwrite = 0;
  logic [1:0]   mem_wbsel = 0;
  logic [4:0]   mem_rd = 0;
  logic [W-1:0] mem_alu_result = 0, mem_load_data = 0, mem_pc_plus8 = 0;
  logic [2:0]   mem_load_type = 0;
  logic         stall = 0, flush = 0;
  logic         RegWrite, wb_valid;
  logic [4:0]   Write_register;
  logic [W-1:0] Write_data;
  logic [31:0]  retired;

  mem_wb_stage #(.MIP_BUS(W)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_wbsel(mem_wbsel),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc_plus8(mem_pc_plus8), .mem_load_type(mem_load_type),
    .stall(stall), .flush(flush),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .wb_valid(wb_valid), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid, regwrite;
    logic [1:0]  wbsel;
    logic [4:0]  rd;
    logic [31:0] alu, ld, pc8;
    logic [2:0]  ltype;
    logic        e_rw, e_v;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input vec_t v);
    mem_valid = v.valid; mem_regwrite = v.regwrite; mem_wbsel = v.wbsel;
    mem_rd = v.rd; mem_alu_result = v.alu; mem_load_data = v.ld;
    mem_pc_plus8 = v.pc8; mem_load_type = v.ltype;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] alu);
    mem_valid = 1; mem_regwrite = 1; mem_wbsel = 2'b00; mem_rd = rd;
    mem_alu_result = alu; mem_load_data = 32'h0; mem_pc_plus8 = 32'h0; mem_load_type = 3'b000;
  endtask

  // next edge, then sample 1ns later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [31:0] exp_ret;
  logic        prev_v;

  initial begin
    // data=0x80FF7F01 for all loads
    vecs[0]  = '{1,1,2'b00, 5, 32'h12345678, 32'h0, 32'h0, 3'b000, 1, 1, 32'h12345678};
    vecs[1]  = '{1,1,2'b00, 0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b000, 0, 1, 32'hDEADBEEF};
    vecs[2]  = '{1,1,2'b01, 8, 32'h00001000, 32'h80FF7F01, 32'h0, 3'b001, 1, 1, EXT ? 32'hFFFFFF80 : 32'h80FF7F01};
    vecs[3]  = '{1,1,2'b01, 9, 32'h00001001, 32'h80FF7F01, 32'h0, 3'b010, 1, 1, EXT ? 32'h000000FF : 32'h80FF7F01};
    vecs[4]  = '{1,1,2'b01,10, 32'h00001002, 32'h80FF7F01, 32'h0, 3'b011, 1, 1, EXT ? 32'h00007F01 : 32'h80FF7F01};
    vecs[5]  = '{1,1,2'b01,11, 32'h00001000, 32'h80FF7F01, 32'h0, 3'b100, 1, 1, EXT ? 32'h000080FF : 32'h80FF7F01};
    vecs[6]  = '{1,1,2'b01,12, 32'h00001000, 32'h80FF7F01, 32'h0, 3'b011, 1, 1, EXT ? 32'hFFFF80FF : 32'h80FF7F01};
    vecs[7]  = '{1,1,2'b01,13, 32'h00001003, 32'h80FF7F01, 32'h0, 3'b111, 1, 1, 32'h80FF7F01};
    vecs[8]  = '{1,1,2'b01,14, 32'h00001003, 32'h80FF7F01, 32'h0, 3'b001, 1, 1, EXT ? 32'h00000001 : 32'h80FF7F01};
    vecs[9]  = '{1,1,2'b11, 3, 32'hCAFEF00D, 32'h11111111, 32'h22222222, 3'b000, 0, 1, 32'h0};
    vecs[10] = '{0,1,2'b00, 4, 32'h0BADC0DE, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0BADC0DE};
    vecs[11] = '{1,0,2'b00, 6, 32'h00000066, 32'h0, 32'h0, 3'b000, 0, 1, 32'h00000066};
    vecs[12] = '{1,1,2'b10,31, 32'h00000000, 32'h0, 32'h00400010, 3'b000, 1, 1, 32'h00400010};

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, wb_valid}, 0);
    check("rst_rw", {31'd0, RegWrite}, 0);
    check("rst_wr", {27'd0, Write_register}, 0);
    check("rst_wd", Write_data, 0);
    check("rst_ret", retired, 0);
    @(negedge clk) rst = 0;

    // table vectors
    exp_ret = 0; prev_v = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk) drive(vecs[i]);
      tick();
      exp_ret += {31'd0, prev_v};
      prev_v = vecs[i].valid;
      check($sformatf("v%0d_rw", i), {31'd0, RegWrite}, {31'd0, vecs[i].e_rw});
      check($sformatf("v%0d_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].e_v});
      check($sformatf("v%0d_wr", i), {27'd0, Write_register}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d_wd", i), Write_data, vecs[i].e_wd);
      check($sformatf("v%0d_ret", i), retired, exp_ret);
    end

    // flush alone: incoming squashed, outgoing still counted
    @(negedge clk) drive_alu(5'd20, 32'h20202020);
    tick(); exp_ret += {31'd0, prev_v};
    @(negedge clk) begin drive_alu(5'd21, 32'h21212121); flush = 1; end
    tick(); exp_ret += 1;
    check("fl_valid", {31'd0, wb_valid}, 0);
    check("fl_rw", {31'd0, RegWrite}, 0);
    check("fl_ret", retired, exp_ret);
    @(negedge clk) begin flush = 0; mem_valid = 0; end
    tick();
    check("fl_ret_after", retired, exp_ret);

    // stall holds for 3 cycles, then stall+flush squashes
    @(negedge clk) drive_alu(5'd7, 32'hAAAA5555);
    tick();
    check("st_load_wd", Write_data, 32'hAAAA5555);
    exp_ret = retired;  // resync not needed for checks below; retired compared relative
    @(negedge clk) begin stall = 1; drive_alu(5'd9, 32'h99999999); end
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("st%0d_wd", c), Write_data, 32'hAAAA5555);
      check($sformatf("st%0d_wr", c), {27'd0, Write_register}, 32'd7);
      check($sformatf("st%0d_rw", c), {31'd0, RegWrite}, 1);
      check($sformatf("st%0d_ret", c), retired, exp_ret);
    end
    @(negedge clk) flush = 1;
    tick();
    check("stfl_valid", {31'd0, wb_valid}, 0);
    check("stfl_rw", {31'd0, RegWrite}, 0);
    @(negedge clk) begin stall = 0; flush = 0; end

    // link then mid-cycle reset
    @(negedge clk) begin
      mem_valid = 1; mem_regwrite = 1; mem_wbsel = 2'b10; mem_rd = 5'd31;
      mem_pc_plus8 = 32'h00400010; mem_alu_result = 32'h0;
    end
    tick();
    check("lk_wd", Write_data, 32'h00400010);
    check("lk_rw", {31'd0, RegWrite}, 1);
    #2 rst = 1;
    #1;
    check("mr_valid", {31'd0, wb_valid}, 0);
    check("mr_rw", {31'd0, RegWrite}, 0);
    check("mr_wr", {27'd0, Write_register}, 0);
    check("mr_wd", Write_data, 0);
    check("mr_ret", retired, 0);
    @(negedge clk) begin rst = 0; mem_valid = 0; end

    // counter wrap
    @(negedge clk) drive_alu(5'd2, 32'h00000002);
    tick();
    @(negedge clk) begin stall = 1; mem_valid = 0; force dut.retired_q = 32'hFFFFFFFF; end
    #1 release dut.retired_q;
    tick();
    check("wr_pre", retired, 32'hFFFFFFFF);
    @(negedge clk) stall = 0;
    tick();
    check("wr_ret", retired, 32'h0);
    check("wr_valid", {31'd0, wb_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
